// File: rtl/uart_buf_core_if.sv
// ---------------------------------------------------------------------------
// uart_buf_core_if
// Bus-side handshake bundle for uart_buf_core.
//   tx_data  / tx_valid / tx_ready : push channel into the TX FIFO
//   rx_data  / rx_valid / rx_ready : pop channel out of the RX FIFO (show-ahead)
// master = bus-side register logic, slave = the UART core.
// ---------------------------------------------------------------------------
interface uart_buf_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_buf_core.sv
// ---------------------------------------------------------------------------
// uart_buf_core
// Buffered UART transceiver: TX FIFO -> TX frame FSM -> tx pin, and
// rx pin -> 2-flop synchroniser -> mid-bit sampling RX FSM -> RX FIFO.
//
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   bus (slave)     : tx_data/tx_valid/tx_ready push, rx_data/rx_valid/rx_ready pop
//   rx              : asynchronous serial input
//   tx              : registered serial output, idle high
//   tx_busy         : TX FSM not idle
//   tx_end          : pulse in the last cycle of every stop bit
//   rx_frame_err    : pulse when a stop bit samples 0
//   rx_parity_err   : pulse on parity mismatch (0 when parity is disabled)
//   rx_overflow     : pulse when a good frame is dropped on a full RX FIFO
//
// Build option: define UART_PARITY_EN to insert a parity bit after the data
// bits (even parity, or odd when PARITY_ODD = 1).
// ---------------------------------------------------------------------------
module uart_buf_core #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk,
    input  logic           rst,
    uart_buf_core_if.slave bus,
    input  logic           rx,
    output logic           tx,
    output logic           tx_busy,
    output logic           tx_end,
    output logic           rx_frame_err,
    output logic           rx_parity_err,
    output logic           rx_overflow
);
    localparam int BIT_CNT = CLK_HZ / BAUD;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(BIT_CNT);
    localparam int BW      = $clog2(DATA_W);

    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(BIT_CNT - 2);
    localparam logic [CW-1:0] HALF_CNT = CW'(BIT_CNT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

`ifdef UART_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- TX FIFO
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wptr_reg, tx_rptr_reg;
    logic              tx_empty, tx_full, tx_push;
    logic [DATA_W-1:0] tx_head;

    assign tx_empty     = (tx_wptr_reg == tx_rptr_reg);
    assign tx_full      = (tx_wptr_reg[AW] != tx_rptr_reg[AW]) &&
                          (tx_wptr_reg[AW-1:0] == tx_rptr_reg[AW-1:0]);
    assign tx_push      = bus.tx_valid && !tx_full;
    assign bus.tx_ready = !tx_full;
    assign tx_head      = tx_mem[tx_rptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push && !rst) begin
            tx_mem[tx_wptr_reg[AW-1:0]] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_reg <= '0;
        end else if (tx_push) begin
            tx_wptr_reg <= tx_wptr_reg + PTR_ONE;
        end
    end

    // ----------------------------------------------------------------- TX FSM
    state_t            tx_state_reg;
    logic [CW-1:0]     tx_cnt_reg;
    logic [BW-1:0]     tx_bit_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic              tx_reg, tx_end_reg;
`ifdef UART_PARITY_EN
    logic              tx_par_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
            tx_end_reg   <= 1'b0;
            tx_rptr_reg  <= '0;
`ifdef UART_PARITY_EN
            tx_par_reg   <= 1'b0;
`endif
        end else begin
            tx_end_reg <= 1'b0;
            case (tx_state_reg)
                S_IDLE: begin
                    if (!tx_empty) begin
                        tx_shift_reg <= tx_head;
                        tx_rptr_reg  <= tx_rptr_reg + PTR_ONE;
`ifdef UART_PARITY_EN
                        tx_par_reg   <= (^tx_head) ^ PAR_SENSE;
`endif
                        tx_reg       <= 1'b0;
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_reg == LAST_CNT) begin
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= '0;
                        tx_reg       <= tx_shift_reg[0];
                        tx_shift_reg <= tx_shift_reg >> 1;
                        tx_state_reg <= S_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_reg == LAST_CNT) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_reg       <= tx_par_reg;
                            tx_state_reg <= S_PARITY;
`else
                            tx_reg       <= 1'b1;
                            tx_state_reg <= S_STOP;
`endif
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + BIT_ONE;
                            tx_reg       <= tx_shift_reg[0];
                            tx_shift_reg <= tx_shift_reg >> 1;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tx_cnt_reg == LAST_CNT) begin
                        tx_cnt_reg   <= '0;
                        tx_reg       <= 1'b1;
                        tx_state_reg <= S_STOP;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    // Registered pulse: set one cycle early so it is high
                    // exactly during the final stop-bit cycle.
                    if (tx_cnt_reg == PRE_CNT) begin
                        tx_end_reg <= 1'b1;
                    end
                    if (tx_cnt_reg == LAST_CNT) begin
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= S_IDLE;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                    end
                end
                default: tx_state_reg <= S_IDLE;
            endcase
        end
    end

    assign tx      = tx_reg;
    assign tx_end  = tx_end_reg;
    assign tx_busy = (tx_state_reg != S_IDLE);

    // ------------------------------------------------------------ RX input
    logic rx_meta_reg, rx_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       rx_wptr_reg, rx_rptr_reg;
    logic              rx_empty, rx_full, rx_pop, rx_push, rx_stop_done;
    logic [DATA_W-1:0] rx_shift_reg;

    assign rx_empty     = (rx_wptr_reg == rx_rptr_reg);
    assign rx_full      = (rx_wptr_reg[AW] != rx_rptr_reg[AW]) &&
                          (rx_wptr_reg[AW-1:0] == rx_rptr_reg[AW-1:0]);
    assign rx_pop       = !rx_empty && bus.rx_ready;
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_mem[rx_rptr_reg[AW-1:0]];

    state_t        rx_state_reg;
    logic [CW-1:0] rx_cnt_reg;
    logic [BW-1:0] rx_bit_reg;
    logic          rx_par_ok;
    logic          rx_frame_err_reg, rx_overflow_reg;

`ifdef UART_PARITY_EN
    logic rx_par_reg, rx_parity_err_reg;
    assign rx_par_ok     = (rx_par_reg == ((^rx_shift_reg) ^ PAR_SENSE));
    assign rx_parity_err = rx_parity_err_reg;
`else
    assign rx_par_ok     = 1'b1;
    assign rx_parity_err = 1'b0;
`endif

    assign rx_stop_done = (rx_state_reg == S_STOP) && (rx_cnt_reg == LAST_CNT);
    // A full FIFO still accepts the frame when a pop frees a slot this cycle.
    assign rx_push      = rx_stop_done && rx_sync_reg && rx_par_ok && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push && !rst) begin
            rx_mem[rx_wptr_reg[AW-1:0]] <= rx_shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_reg <= '0;
            rx_rptr_reg <= '0;
        end else begin
            if (rx_push) rx_wptr_reg <= rx_wptr_reg + PTR_ONE;
            if (rx_pop)  rx_rptr_reg <= rx_rptr_reg + PTR_ONE;
        end
    end

    // ----------------------------------------------------------------- RX FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg     <= S_IDLE;
            rx_cnt_reg       <= '0;
            rx_bit_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_frame_err_reg <= 1'b0;
            rx_overflow_reg  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_reg        <= 1'b0;
            rx_parity_err_reg <= 1'b0;
`endif
        end else begin
            rx_frame_err_reg <= 1'b0;
            rx_overflow_reg  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err_reg <= 1'b0;
`endif
            case (rx_state_reg)
                S_IDLE: begin
                    if (!rx_sync_reg) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= S_START;
                    end
                end
                S_START: begin
                    // Half a bit in: a line that is high again was a glitch.
                    if (rx_cnt_reg == HALF_CNT) begin
                        rx_cnt_reg <= '0;
                        rx_bit_reg <= '0;
                        rx_state_reg <= rx_sync_reg ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_reg == LAST_CNT) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_W-1:1]};
                        if (rx_bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state_reg <= S_PARITY;
`else
                            rx_state_reg <= S_STOP;
`endif
                        end else begin
                            rx_bit_reg <= rx_bit_reg + BIT_ONE;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_cnt_reg == LAST_CNT) begin
                        rx_cnt_reg   <= '0;
                        rx_par_reg   <= rx_sync_reg;
                        rx_state_reg <= S_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (rx_stop_done) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= S_IDLE;
                        if (!rx_sync_reg) begin
                            rx_frame_err_reg <= 1'b1;
                        end
`ifdef UART_PARITY_EN
                        else if (!rx_par_ok) begin
                            rx_parity_err_reg <= 1'b1;
                        end
`endif
                        else if (rx_full && !rx_pop) begin
                            rx_overflow_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                default: rx_state_reg <= S_IDLE;
            endcase
        end
    end

    assign rx_frame_err = rx_frame_err_reg;
    assign rx_overflow  = rx_overflow_reg;
endmodule

// File: doc/uart_buf_core.md
# uart_buf_core

Buffered, parametrised UART transceiver for the SoC peripheral bus. It replaces the fixed 8-bit, unbuffered TX/RX pairing with the following:
- configurable baud rate and data width;
- independent TX and RX FIFOs with valid/ready handshakes;
- mid-bit RX sampling with glitch rejection and frame-error detection;
- optional parity.

It sits between the bus-side register logic and the external serial pins (e.g. an HC-05 module).

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate. `BIT_CNT = CLK_HZ/BAUD` (truncating); must be ≥ 4.
- `DATA_W`, 8, data bits per frame (5..8).
- `FIFO_DEPTH`, 16, entries per FIFO; power of 2, ≥ 2.
- `PARITY_ODD`, 0, parity sense: 0 = even, 1 = odd. Used only when `UART_PARITY_EN` is defined.

- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_data` in DATA_W: byte to transmit.
- `tx_valid` in 1: push request for `tx_data`.
- `tx_ready` out 1: TX FIFO not full.
- `rx_data` out DATA_W: head of RX FIFO (show-ahead).
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: pop request for the RX FIFO.
- `rx` in 1: serial input, asynchronous.
- `tx` out 1: serial output, registered, idle high.
- `tx_busy` out 1: TX FSM not in IDLE.
- `tx_end` out 1: one-cycle pulse in the last cycle of each stop bit.
- `rx_frame_err` out 1: one-cycle pulse when a received stop bit reads 0.
- `rx_parity_err` out 1: one-cycle pulse on a parity mismatch.
- `rx_overflow` out 1: one-cycle pulse when a good frame is dropped because the RX FIFO is full.

## Operation
- **Push and pop.**
  - A push occurs when `tx_valid && tx_ready`.
  - A pop occurs when `rx_valid && rx_ready`.
  - Push/pop requests are ignored while `rst` is high.
- **TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.**
  - In IDLE with the TX FIFO non-empty: pop the FIFO, load the shift register, and enter START. `tx` goes low on the next cycle.
  - Each of START, DATA (per bit), PARITY and STOP lasts exactly `BIT_CNT` cycles.
  - Data is sent LSB first. STOP drives `tx` high.
  - After STOP the FSM spends one cycle in IDLE before the next START.
- **RX input and FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.**
  - `rx` passes through a 2-flop synchroniser; all RX logic uses the synchronised signal.
  - IDLE: a synchronised low enters START.
  - START: wait `BIT_CNT/2` cycles, then sample. If the sample is high, treat it as a glitch and return to IDLE.
  - DATA/PARITY/STOP: sample every `BIT_CNT` cycles after the START sample. Data is shifted LSB first.
- **RX at the STOP sample:**
  - Stop bit = 0: pulse `rx_frame_err`, discard the frame.
  - Parity mismatch (stop bit = 1): pulse `rx_parity_err`, discard the frame.
  - Otherwise, if the RX FIFO is not full, push the frame.
  - If the FIFO is full, pulse `rx_overflow`, drop the frame, and leave the FIFO contents unchanged.
  - In all cases the FSM returns to IDLE immediately after the STOP sample; it does not wait for the end of the stop bit.
- **Simultaneous events.**
  - RX FIFO full with a pop and an internal push in the same cycle: both succeed; no overflow.
  - TX FIFO: a bus push and an FSM pop in the same cycle both succeed.
- **FIFOs.** Circular buffers with `log2(FIFO_DEPTH)+1`-bit read/write pointers. Full and empty are decoded from the MSB and the address bits. Pointers wrap to 0.

## Timing
- **Reset values (cycle after `rst` is sampled high):**
  - `tx`=1, `tx_busy`=0, `tx_end`=0.
  - `rx_valid`=0, `tx_ready`=1.
  - All error pulses 0.
  - FIFOs empty, both FSMs in IDLE, synchroniser preset to 1.
- **Reset mid-frame:** the frame is abandoned and `tx` returns high on the next cycle. Partial RX data is discarded.
- **TX latency:** push into an empty FIFO with the FSM idle at cycle N → start bit begins at N+2.
- **Frame length:** `(2 + DATA_W [+1]) × BIT_CNT` cycles. Back-to-back frames are separated by one idle cycle.
- **RX latency:** `rx_valid` rises 3 cycles after the STOP sample point; this includes the synchroniser delay.
- **Flag timing:** `tx_ready` and `rx_valid` are combinational from the FIFO pointers and update the cycle after a push/pop.

## Configuration
- **`UART_PARITY_EN` defined:**
  - A PARITY bit is inserted after DATA: the XOR of the data bits, inverted when `PARITY_ODD`=1.
  - RX checks the parity bit and pulses `rx_parity_err` on a mismatch.
- **`UART_PARITY_EN` undefined:**
  - No PARITY state; the frame is 1 start + `DATA_W` + 1 stop.
  - `rx_parity_err` is tied to 0.

## Test plan
All scenarios use CLK_HZ=50_000_000, BAUD=5_000_000 (BIT_CNT=10), DATA_W=8, FIFO_DEPTH=16.
- **Single byte:** push 0xA5 → `tx` low 10 cycles, then 1,0,1,0,0,1,0,1 for 10 cycles each, then high 10 cycles. `tx_end` pulses once, at cycle 99 of the frame.
- **Loopback:** `tx`→`rx`, push 0x00, 0xFF, 0x3C → RX pops return 0x00, 0xFF, 0x3C in order; no error pulses.
- **TX FIFO full:** 17 back-to-back pushes → all accepted and `tx_ready`=0 after the 17th; an 18th push is refused until the first frame ends.
- **RX errors:**
  - Drive a frame for 0x55 with stop bit 0 → `rx_frame_err` pulses once, `rx_valid` stays 0.
  - Hold `rx_ready`=0 and send 17 frames → `rx_overflow` pulses on the 17th; pops return the first 16 bytes.
- **Reset mid-frame:** assert `rst` during data bit 3 → `tx`=1, `tx_busy`=0, `rx_valid`=0 on the next cycle.
- **Parity (`UART_PARITY_EN`, `PARITY_ODD`=0):** push 0x07 → parity bit 1. An injected flipped parity bit → `rx_parity_err` pulse, byte discarded.
